dbus_arbiter: RTL and testbench
===============================

DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-002 The block SHALL have no parameters; the requester count is fixed at 2.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 ireq0  in  dbus_req_t  requester 0 (memory stage) request: valid, addr, size, strobe, data.
REQ-006 iresp0  out  dbus_resp_t  response to requester 0: addr_ok, data_ok, data.
REQ-007 ireq1  in  dbus_req_t  requester 1 (auxiliary master) request.
REQ-008 iresp1  out  dbus_resp_t  response to requester 1.
REQ-009 oreq  out  dbus_req_t  request to the shared data bus, registered.
REQ-010 oresp  in  dbus_resp_t  response from the shared data bus.
REQ-011 busy  out  1  high while a transaction is outstanding.
REQ-012 owner  out  1  index of the current or last granted requester.

Function
REQ-013 The state machine SHALL have three states:
- IDLE: no transaction outstanding.
- BUSY: oreq.valid high, waiting for completion.
- COOL: one-cycle recovery after a transaction.
REQ-014 In IDLE, with any eligible ireqN.valid high, the block SHALL select a winner, latch its whole request into oreq, set owner, and enter BUSY at the next edge.
- oreq.valid SHALL be high starting one cycle after the request is seen.
REQ-015 In BUSY, oreq SHALL hold the latched request unchanged, regardless of later changes on ireqN.
REQ-016 In BUSY, in a cycle where oresp.addr_ok & oresp.data_ok are both high:
- iresp[owner] SHALL carry oresp combinationally in the same cycle;
- the next edge SHALL clear oreq.valid and enter COOL.
REQ-017 The non-owner iresp, and both iresp outside BUSY, SHALL be all zeros.
REQ-018 In BUSY, oresp.addr_ok without data_ok SHALL not complete the transaction.
REQ-019 In COOL:
- the finished owner's valid SHALL be ignored;
- the other requester is still eligible and SHALL be granted as in IDLE, entering BUSY at the next edge;
- with no eligible request, the next state SHALL be IDLE.
REQ-020 A requester SHALL keep valid high until it sees data_ok. It then deasserts valid in the following cycle; COOL exists so that this trailing valid is never regranted.
REQ-021 Simultaneous valid requests in IDLE or COOL SHALL follow the priority rule in REQ-028/029. The loser SHALL see zero responses and is served after the current transaction.
REQ-022 A requester dropping valid while not granted SHALL simply lose eligibility; nothing SHALL be latched for it.
REQ-023 busy SHALL equal (state == BUSY).
REQ-024 A strobe of zero SHALL mean read and a nonzero strobe SHALL mean write; the block SHALL pass both through without inspection.

Reset
REQ-025 rst SHALL immediately force:
- state IDLE, oreq all zeros (valid 0), busy 0, owner 0;
- the round-robin pointer to 0 (requester 0 preferred next).
REQ-026 A reset asserted mid-transaction SHALL abandon it; a data_ok arriving after reset release SHALL be ignored because the state is IDLE.
REQ-027 The first grant after reset SHALL follow the normal rules with no extra delay.

Configuration
REQ-028 With DBUS_ARB_ROUND_ROBIN_EN defined:
- on a tie, the requester not granted most recently SHALL win;
- the pointer SHALL update on every grant.
REQ-029 Without DBUS_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win ties (fixed priority) and the pointer logic SHALL be absent.

Verification
REQ-030 Single read: ireq0 valid, addr 0x8000_0010, strobe 0; bus answers data_ok 3 cycles later with data 0xDEAD_BEEF -> oreq.valid rises 1 cycle after the request; iresp0.data = 0xDEAD_BEEF in the data_ok cycle; iresp1 stays 0.
REQ-031 Tie: both valid in the same cycle, addr0 0x100 and addr1 0x200:
- fixed priority -> oreq.addr 0x100, then 0x200 after COOL;
- round-robin with pointer 1 -> 0x200 first.
REQ-032 Trailing valid: ireq0 held one cycle after data_ok -> no second oreq for ireq0; oreq.valid low for at least 1 cycle.
REQ-033 Back-to-back: ireq1 waiting while ireq0 completes -> ireq1 granted from COOL; oreq.valid low for exactly 1 cycle between the two transactions.
REQ-034 Write with strobe 0xF0, data 0x1122334455667788: bus returns addr_ok only for 2 cycles, then addr_ok+data_ok -> completes only on the final cycle; oreq fields unchanged throughout.
REQ-035 Reset while in BUSY -> oreq.valid 0 immediately; busy 0; a data_ok delivered after reset release produces no iresp activity.

Source files
------------

// File: rtl/dbus_arbiter.sv
// Two-requester data-bus arbiter: latches the winning request onto a shared bus and
// routes its response back. Define DBUS_ARB_ROUND_ROBIN_EN for round-robin tie-breaking.
package dbus_arbiter_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dbus_arbiter
    import dbus_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  dbus_req_t  ireq0,
    output dbus_resp_t iresp0,
    input  dbus_req_t  ireq1,
    output dbus_resp_t iresp1,
    output dbus_req_t  oreq,
    input  dbus_resp_t oresp,
    output logic       busy,
    output logic       owner
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_COOL = 2'd2
    } state_e;

    state_e    state_q;
    dbus_req_t oreq_q;
    logic      busy_q;
    logic      owner_q;
`ifdef DBUS_ARB_ROUND_ROBIN_EN
    logic      rr_ptr_q;
`endif

    logic      elig0;
    logic      elig1;
    logic      grant;
    logic      grant_idx_d;
    dbus_req_t grant_req_d;
    logic      done;

    // In COOL the owner that just finished is still holding its trailing valid; mask it.
    always_comb begin
        elig0 = ireq0.valid && !(state_q == ST_COOL && !owner_q);
        elig1 = ireq1.valid && !(state_q == ST_COOL &&  owner_q);
        grant = (state_q != ST_BUSY) && (elig0 || elig1);
`ifdef DBUS_ARB_ROUND_ROBIN_EN
        grant_idx_d = (elig0 && elig1) ? rr_ptr_q : elig1;
`else
        grant_idx_d = !elig0;
`endif
        grant_req_d = grant_idx_d ? ireq1 : ireq0;
        done        = (state_q == ST_BUSY) && oresp.addr_ok && oresp.data_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            oreq_q   <= '0;
            busy_q   <= 1'b0;
            owner_q  <= 1'b0;
`ifdef DBUS_ARB_ROUND_ROBIN_EN
            rr_ptr_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE, ST_COOL: begin
                    if (grant) begin
                        oreq_q   <= grant_req_d;
                        owner_q  <= grant_idx_d;
                        busy_q   <= 1'b1;
                        state_q  <= ST_BUSY;
`ifdef DBUS_ARB_ROUND_ROBIN_EN
                        rr_ptr_q <= !grant_idx_d;
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (done) begin
                        oreq_q.valid <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= ST_COOL;
                    end
                end
                default: begin
                    oreq_q  <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Responses pass through unregistered, only to the current owner and only while BUSY.
    always_comb begin
        iresp0 = '0;
        iresp1 = '0;
        if (state_q == ST_BUSY) begin
            if (owner_q) iresp1 = oresp;
            else         iresp0 = oresp;
        end
    end

    assign oreq  = oreq_q;
    assign busy  = busy_q;
    assign owner = owner_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed testbench for dbus_arbiter: single read, tie, trailing valid, back-to-back,
// held write with addr_ok-only stalls, and reset during a transaction.
module tb_dbus_arbiter;
    import dbus_arbiter_pkg::*;

`ifdef DBUS_ARB_ROUND_ROBIN_EN
    localparam bit TIE_FIRST = 1'b1;
`else
    localparam bit TIE_FIRST = 1'b0;
`endif
    localparam logic [31:0] TIE_ADDR0 = 32'h0000_0100;
    localparam logic [31:0] TIE_ADDR1 = 32'h0000_0200;

    logic       clk;
    logic       rst;
    dbus_req_t  ireq0;
    dbus_req_t  ireq1;
    dbus_resp_t iresp0;
    dbus_resp_t iresp1;
    dbus_req_t  oreq;
    dbus_resp_t oresp;
    logic       busy;
    logic       owner;

    int n_checks;
    int n_fail;

    dbus_arbiter dut (
        .clk    (clk),
        .rst    (rst),
        .ireq0  (ireq0),
        .iresp0 (iresp0),
        .ireq1  (ireq1),
        .iresp1 (iresp1),
        .oreq   (oreq),
        .oresp  (oresp),
        .busy   (busy),
        .owner  (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ireq0    = '0;
        ireq1    = '0;
        oresp    = '0;
        rst      = 1'b1;
        tick();
        tick();
        settle();
        check_eq("rst_oreq",  oreq,  '0);
        check_eq("rst_busy",  busy,  1'b0);
        check_eq("rst_owner", owner, 1'b0);
        rst = 1'b0;

        // Single read from requester 0, completed three cycles after the grant
        tick();
        ireq0.valid  = 1'b1;
        ireq0.addr   = 32'h8000_0010;
        ireq0.size   = 3'd2;
        ireq0.strobe = 8'h00;
        settle();
        check_eq("rd_valid_not_yet", oreq.valid, 1'b0);
        tick();
        settle();
        check_eq("rd_oreq_valid", oreq.valid, 1'b1);
        check_eq("rd_oreq_addr",  oreq.addr,  32'h8000_0010);
        check_eq("rd_busy",       busy,       1'b1);
        check_eq("rd_owner",      owner,      1'b0);
        tick();
        tick();
        oresp.addr_ok = 1'b1;
        oresp.data_ok = 1'b1;
        oresp.data    = 64'h0000_0000_DEAD_BEEF;
        settle();
        check_eq("rd_iresp0_data",   iresp0.data,    64'h0000_0000_DEAD_BEEF);
        check_eq("rd_iresp0_dataok", iresp0.data_ok, 1'b1);
        check_eq("rd_iresp1_zero",   iresp1,         '0);
        // COOL: requester 0 still shows its trailing valid
        tick();
        oresp = '0;
        settle();
        check_eq("trail_cool_valid", oreq.valid, 1'b0);
        check_eq("trail_cool_busy",  busy,       1'b0);
        check_eq("trail_cool_resp0", iresp0,     '0);
        tick();
        ireq0 = '0;
        settle();
        check_eq("trail_idle_valid", oreq.valid, 1'b0);
        tick();
        settle();
        check_eq("trail_still_idle", oreq.valid, 1'b0);

        // Tie between both requesters, then back-to-back service of the loser
        ireq0.valid = 1'b1;
        ireq0.addr  = TIE_ADDR0;
        ireq1.valid = 1'b1;
        ireq1.addr  = TIE_ADDR1;
        tick();
        settle();
        check_eq("tie_first_addr",  oreq.addr, TIE_FIRST ? TIE_ADDR1 : TIE_ADDR0);
        check_eq("tie_first_owner", owner,     TIE_FIRST);
        oresp.addr_ok = 1'b1;
        oresp.data_ok = 1'b1;
        oresp.data    = 64'h55;
        settle();
        check_eq("tie_winner_data", TIE_FIRST ? iresp1.data : iresp0.data, 64'h55);
        check_eq("tie_loser_zero",  TIE_FIRST ? iresp0 : iresp1, '0);
        tick();
        oresp = '0;
        settle();
        check_eq("b2b_gap_valid", oreq.valid, 1'b0);
        tick();
        if (TIE_FIRST) ireq1 = '0;
        else           ireq0 = '0;
        settle();
        check_eq("b2b_second_valid", oreq.valid, 1'b1);
        check_eq("b2b_second_addr",  oreq.addr,  TIE_FIRST ? TIE_ADDR0 : TIE_ADDR1);
        check_eq("b2b_second_owner", owner,      !TIE_FIRST);
        oresp.addr_ok = 1'b1;
        oresp.data_ok = 1'b1;
        tick();
        oresp = '0;
        tick();
        ireq0 = '0;
        ireq1 = '0;
        settle();
        check_eq("b2b_done_idle", busy, 1'b0);

        // Write with two addr_ok-only cycles before completion; requester changes data meanwhile
        tick();
        ireq0.valid  = 1'b1;
        ireq0.addr   = 32'h0000_1000;
        ireq0.size   = 3'd3;
        ireq0.strobe = 8'hF0;
        ireq0.data   = 64'h1122_3344_5566_7788;
        tick();
        ireq0.data   = 64'hFFFF_FFFF_FFFF_FFFF;
        ireq0.strobe = 8'h0F;
        oresp.addr_ok = 1'b1;
        settle();
        check_eq("wr_strobe",       oreq.strobe,    8'hF0);
        check_eq("wr_data",         oreq.data,      64'h1122_3344_5566_7788);
        check_eq("wr_addrok_only",  iresp0.data_ok, 1'b0);
        tick();
        settle();
        check_eq("wr_stall1_busy",  busy,           1'b1);
        check_eq("wr_stall1_data",  oreq.data,      64'h1122_3344_5566_7788);
        tick();
        oresp.data_ok = 1'b1;
        settle();
        check_eq("wr_final_busy",   busy,           1'b1);
        check_eq("wr_final_strobe", oreq.strobe,    8'hF0);
        check_eq("wr_final_dataok", iresp0.data_ok, 1'b1);
        tick();
        oresp = '0;
        settle();
        check_eq("wr_cool_busy",    busy,           1'b0);
        tick();
        ireq0 = '0;
        tick();

        // Reset asserted while requester 1 is being served
        ireq1.valid = 1'b1;
        ireq1.addr  = 32'h0000_2000;
        tick();
        settle();
        check_eq("rb_busy_before",  busy,       1'b1);
        check_eq("rb_owner_before", owner,      1'b1);
        rst = 1'b1;
        ireq1 = '0;
        settle();
        check_eq("rb_valid_async",  oreq.valid, 1'b0);
        check_eq("rb_busy_async",   busy,       1'b0);
        check_eq("rb_owner_async",  owner,      1'b0);
        tick();
        rst = 1'b0;
        oresp.addr_ok = 1'b1;
        oresp.data_ok = 1'b1;
        oresp.data    = 64'hABCD;
        settle();
        check_eq("rb_late_resp0", iresp0, '0);
        check_eq("rb_late_resp1", iresp1, '0);
        tick();
        oresp = '0;
        settle();
        check_eq("rb_idle_valid", oreq.valid, 1'b0);
        check_eq("rb_idle_busy",  busy,       1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
